addsub_sched: RTL and testbench
===============================

Name: addsub_sched

Overview:
Command scheduler that shares one poly_addsub unit between two requesters, for example the decompress path and the message-encode path.
- Requests are arbitrated round-robin and queued in a small FIFO.
- Each request is issued to the unit as a start pulse with its mode, and the scheduler waits for done.
- A tagged completion, with an error flag on watchdog timeout, is returned on a shared response bus.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 3, requester tag width
TIMEOUT, 320, cycles in S_WAIT before abort (must exceed unit latency of 259)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
r0_valid  in  1  requester 0 command valid
r0_ready  out  1  requester 0 command accepted this cycle
r0_mode  in  1  0=add, 1=sub
r0_tag  in  TAG_W  requester 0 tag
r1_valid, r1_ready, r1_mode, r1_tag  as r0, for requester 1
rsp_valid  out  1  one-cycle completion pulse
rsp_src  out  1  requester index of completed command
rsp_tag  out  TAG_W  tag of completed command
rsp_err  out  1  1 = aborted by timeout
au_start  out  1  start pulse to poly_addsub
au_mode  out  1  mode to poly_addsub, held stable during the op
au_done  in  1  done pulse from poly_addsub
au_busy  in  1  busy from poly_addsub
sched_busy  out  1  FIFO non-empty or executor not idle
fifo_count  out  clog2(DEPTH)+1  queued entries

Behaviour:
- Reset (async, rst_n low):
  - Executor state is S_IDLE; FIFO is emptied; RR pointer = 0.
  - All outputs are 0: rsp_*, au_start, au_mode, sched_busy, fifo_count.
  - A reset mid-operation drops the in-flight command and all queued commands; no response is issued for them.
- Arbitration (combinational ready, push at clock edge):
  - At most one grant per cycle, and only when the FIFO is not full.
  - Both valid: the RR pointer's requester wins, then the pointer flips to the other.
  - Single valid: that requester wins and the pointer is unchanged.
  - FIFO full: r0_ready = r1_ready = 0.
  - A push stores {src, mode, tag}.
  - Push and pop in the same cycle are allowed, including when full (the pop frees the slot next cycle only; ready is still computed from the current full flag).
- Executor FSM:
  - S_IDLE: if the FIFO is non-empty and au_busy=0, pop the head into cur_{src,mode,tag}, then go to S_ISSUE. Otherwise stay.
  - S_ISSUE: au_start=1 for exactly this cycle and au_mode=cur_mode. Clear the timer, then go to S_WAIT.
  - S_WAIT: au_mode is held.
    - If au_done=1: go to S_RESP with err=0.
    - Else if timer==TIMEOUT-1: go to S_RESP with err=1.
    - Else timer++.
  - S_RESP: rsp_valid=1 for one cycle with cur_src, cur_tag and err, then go to S_IDLE.
  - au_done seen outside S_WAIT is ignored.
  - After a timeout, S_IDLE does not issue until au_busy=0. The datapath is not reset by the scheduler.
- Latency:
  - A command pushed in cycle t (empty FIFO, unit idle) gets au_start in cycle t+2.
  - au_done in cycle d gives rsp_valid in cycle d+1.
  - Nominal push-to-response is t+262.
- Throughput: back-to-back queued commands have 2 cycles of gap between au_done and the next au_start (RESP, IDLE pop).
- FIFO ordering is strict; there is no reordering between sources.
- Width rules:
  - Timer is clog2(TIMEOUT) bits and does not wrap.
  - FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - fifo_count ranges 0..DEPTH.
- sched_busy = (fifo_count!=0) || (state!=S_IDLE), registered from next-state.
- rsp_* hold their last values except for rsp_valid, which is 0 outside S_RESP.

Decomposition:
- kyber_pkg.vh: MODE_ADD=0, MODE_SUB=1, ADDSUB_LATENCY=259 (start-to-done), and the default SCHED_TIMEOUT.
- Executor state encodings are local parameters.
- One natural sub-module, sched_fifo: synchronous FIFO (DEPTH, width 1+1+TAG_W) with push/pop/full/empty/count, and async active-low reset clearing pointers.

Test Plan:
1. Single request: r0 valid with mode=1, tag=5, with a poly_addsub model (done 259 cycles after start).
   -> au_start at t+2 with au_mode=1, rsp_valid at t+262 with src=0, tag=5, err=0.
2. Simultaneous r0/r1 valid for 4 cycles with distinct tags, pointer starting at 0.
   -> grants alternate r0, r1, r0, r1; responses come in that order with the matching tags.
3. Fill the FIFO to DEPTH=4 while one op is in flight.
   -> the 5th request sees ready=0 until the first pop, then is accepted; fifo_count peaks at 4.
4. Model never asserts done.
   -> rsp_err=1 exactly TIMEOUT cycles after entering S_WAIT. With au_busy held high, the next command is not issued until busy drops.
5. Assert rst_n low 100 cycles into an op with 2 entries queued.
   -> all outputs are 0 immediately, fifo_count=0, no rsp_valid after reset release.
6. Spurious au_done while in S_IDLE with an empty FIFO.
   -> no rsp_valid and the state stays in S_IDLE.

Source files
------------

// File: rtl/addsub_sched_pkg.sv
// Shared constants and types for the poly_addsub command scheduler.
package addsub_sched_pkg;

  // Operation select driven to poly_addsub on au_mode.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Start-to-done latency of poly_addsub in clock cycles.
  localparam int ADDSUB_LATENCY = 259;

  // Default watchdog: cycles spent waiting for done before aborting.
  // Must stay above ADDSUB_LATENCY so a healthy unit never trips it.
  localparam int SCHED_TIMEOUT = 320;

  // Executor states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } exec_state_e;

endpackage

// File: rtl/addsub_sched_fifo.sv
// Synchronous command FIFO for the addsub scheduler. Pointers wrap modulo
// DEPTH (power of two); count runs 0..DEPTH. A push while full or a pop
// while empty is ignored. count_next_o exposes the next-state occupancy so
// the owner can register status flags without an extra cycle of lag.
module addsub_sched_fifo
  import addsub_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [$clog2(DEPTH):0]  count_next_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags, qualified push/pop and next occupancy.
  always_comb begin
    full_o    = (count_q == CNT_W'(DEPTH));
    empty_o   = (count_q == {CNT_W{1'b0}});
    push_ok_s = push_i && !full_o;
    pop_ok_s  = pop_i && !empty_o;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so no stale command survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/addsub_sched.sv
// addsub_sched: shares one poly_addsub unit between two requesters.
// Requests are granted round-robin into a small FIFO; a single executor pops
// one command at a time, pulses au_start, waits for au_done (or a watchdog
// timeout) and returns a tagged completion on the shared response bus.
module addsub_sched
  import addsub_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 3,
  parameter int TIMEOUT = SCHED_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   r0_valid,
  output logic                   r0_ready,
  input  logic                   r0_mode,
  input  logic [TAG_W-1:0]       r0_tag,
  input  logic                   r1_valid,
  output logic                   r1_ready,
  input  logic                   r1_mode,
  input  logic [TAG_W-1:0]       r1_tag,
  output logic                   rsp_valid,
  output logic                   rsp_src,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic                   au_start,
  output logic                   au_mode,
  input  logic                   au_done,
  input  logic                   au_busy,
  output logic                   sched_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 2 + TAG_W;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // Arbitration
  logic             rr_q;
  logic             rr_d;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             push_s;
  logic [ENT_W-1:0] push_data_s;

  // FIFO
  logic             pop_s;
  logic [ENT_W-1:0] head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_next_s;

  // Executor
  exec_state_e      state_q;
  exec_state_e      state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             cur_src_q;
  logic             cur_src_d;
  logic             cur_mode_q;
  logic             cur_mode_d;
  logic [TAG_W-1:0] cur_tag_q;
  logic [TAG_W-1:0] cur_tag_d;
  logic             cur_err_q;
  logic             cur_err_d;

  // Registered outputs
  logic             rsp_valid_q;
  logic             rsp_src_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;
  logic             au_start_q;
  logic             sched_busy_q;

  // Grant at most one requester per cycle; the pointer only moves on a
  // contested cycle. Ready uses the current full flag even if a pop is due.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    rr_d   = rr_q;
    if (fifo_full_s) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (r0_valid && r1_valid) begin
      if (rr_q == 1'b0) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
      rr_d = ~rr_q;
    end else if (r0_valid) begin
      gnt0_s = 1'b1;
    end else if (r1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Entry layout is {src, mode, tag}.
  assign push_s      = gnt0_s | gnt1_s;
  assign push_data_s = gnt1_s ? {1'b1, r1_mode, r1_tag} : {1'b0, r0_mode, r0_tag};
  assign r0_ready    = gnt0_s;
  assign r1_ready    = gnt1_s;

  // Round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  addsub_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .wdata_i      (push_data_s),
    .pop_i        (pop_s),
    .rdata_o      (head_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

  // Executor next state: pop, issue, wait for done or timeout, respond.
  // After a timeout the unit may still be busy, so IDLE waits on au_busy.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cur_src_d  = cur_src_q;
    cur_mode_d = cur_mode_q;
    cur_tag_d  = cur_tag_q;
    cur_err_d  = cur_err_q;
    pop_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s && !au_busy) begin
          pop_s      = 1'b1;
          cur_src_d  = head_s[ENT_W-1];
          cur_mode_d = head_s[ENT_W-2];
          cur_tag_d  = head_s[TAG_W-1:0];
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_d = {TMR_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (au_done) begin
          cur_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          cur_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Executor state, watchdog timer and current-command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= {TMR_W{1'b0}};
      cur_src_q  <= 1'b0;
      cur_mode_q <= 1'b0;
      cur_tag_q  <= {TAG_W{1'b0}};
      cur_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_src_q  <= cur_src_d;
      cur_mode_q <= cur_mode_d;
      cur_tag_q  <= cur_tag_d;
      cur_err_q  <= cur_err_d;
    end
  end

  // Output registers, loaded from next-state so pulses align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_src_q    <= 1'b0;
      rsp_tag_q    <= {TAG_W{1'b0}};
      rsp_err_q    <= 1'b0;
      au_start_q   <= 1'b0;
      sched_busy_q <= 1'b0;
    end else begin
      rsp_valid_q  <= (state_d == S_RESP);
      au_start_q   <= (state_d == S_ISSUE);
      sched_busy_q <= (count_next_s != {CNT_W{1'b0}}) || (state_d != S_IDLE);
      if (state_d == S_RESP) begin
        rsp_src_q <= cur_src_d;
        rsp_tag_q <= cur_tag_d;
        rsp_err_q <= cur_err_d;
      end else begin
        rsp_src_q <= rsp_src_q;
        rsp_tag_q <= rsp_tag_q;
        rsp_err_q <= rsp_err_q;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_src    = rsp_src_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign au_start   = au_start_q;
  assign au_mode    = cur_mode_q;
  assign sched_busy = sched_busy_q;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_addsub_sched.sv
// Self-checking bench for addsub_sched with a behavioural poly_addsub model
// and an in-order completion scoreboard.
module tb_addsub_sched;
  import addsub_sched_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 3;
  localparam int TIMEOUT = 320;
  localparam int LAT     = ADDSUB_LATENCY;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             r0_valid = 1'b0, r0_mode = 1'b0, r1_valid = 1'b0, r1_mode = 1'b0;
  logic [TAG_W-1:0] r0_tag = '0, r1_tag = '0;
  logic             r0_ready, r1_ready;
  logic             rsp_valid, rsp_src, rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic             au_start, au_mode, sched_busy;
  logic             au_done = 1'b0, au_busy = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;

  addsub_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mode(r0_mode), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mode(r1_mode), .r1_tag(r1_tag),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .au_start(au_start), .au_mode(au_mode), .au_done(au_done), .au_busy(au_busy),
    .sched_busy(sched_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  logic mode_q[$];
  logic rr_m = 1'b0;
  int   start_cnt = 0;
  rsp_t mon_e;

  // Unit model controls
  logic done_en = 1'b1, hold_busy = 1'b0, spur = 1'b0;
  logic pend = 1'b0;
  int   done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // poly_addsub model: done LAT cycles after start, busy from start to done.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      au_done <= 1'b0;
      au_busy <= 1'b0;
    end else if (au_start === 1'b1) begin
      pend     <= 1'b1;
      done_cyc <= cyc + LAT;
      au_busy  <= 1'b1;
      au_done  <= spur;
    end else begin
      if (pend && cyc == done_cyc + 1) begin
        pend    <= 1'b0;
        au_busy <= hold_busy;
      end else begin
        au_busy <= pend || hold_busy;
      end
      au_done <= (pend && cyc == done_cyc && done_en) || spur;
    end
  end

  // Scoreboard: responses and issued modes must follow grant order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_src", rsp_src, mon_e.src);
          chk("rsp_tag", rsp_tag, mon_e.tag);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
      if (au_start === 1'b1) begin
        start_cnt <= start_cnt + 1;
        if (mode_q.size() == 0) chk("start_unexpected", au_start, 0);
        else chk("start_mode", au_mode, mode_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic src, input logic mode, input logic [TAG_W-1:0] tag,
                       input logic err, output int t);
    if (src) begin r1_valid = 1'b1; r1_mode = mode; r1_tag = tag; end
    else     begin r0_valid = 1'b1; r0_mode = mode; r0_tag = tag; end
    #1;
    chk("push_ready", src ? r1_ready : r0_ready, 1);
    t = cyc;
    exp_q.push_back(rsp_t'{src: src, tag: tag, err: err});
    mode_q.push_back(mode);
    step();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic wait_ev(input logic rsp, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (rsp ? (rsp_valid === 1'b1) : (au_start === 1'b1)) begin
        at = cyc;
        break;
      end
    end
    chk(rsp ? "rsp_seen" : "start_seen", (at >= 0), 1);
  endtask

  task automatic drain(input int bound);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      step();
      i++;
    end
    chk("drain_empty", exp_q.size(), 0);
    step();
  endtask

  // Requests for n cycles from an empty, idle scheduler; grants predicted
  // from round-robin rules and FIFO occupancy (one pop right after the first grant).
  task automatic arb_phase(input int n, input logic both);
    int occ = 0;
    int g0 = -1;
    logic v0, v1, e0, e1, m0, m1;
    logic [TAG_W-1:0] t0v, t1v;
    for (int i = 0; i < n; i++) begin
      v0  = both ? 1'b1 : 1'($urandom_range(0, 1));
      v1  = both ? 1'b1 : 1'($urandom_range(0, 1));
      m0  = 1'($urandom);
      m1  = 1'($urandom);
      t0v = both ? TAG_W'(2 * i) : TAG_W'($urandom);
      t1v = both ? TAG_W'(2 * i + 1) : TAG_W'($urandom);
      r0_valid = v0; r0_mode = m0; r0_tag = t0v;
      r1_valid = v1; r1_mode = m1; r1_tag = t1v;
      e0 = 1'b0;
      e1 = 1'b0;
      if (occ < DEPTH) begin
        if (v0 && v1) begin
          if (rr_m == 1'b0) e0 = 1'b1; else e1 = 1'b1;
          rr_m = ~rr_m;
        end else if (v0) e0 = 1'b1;
        else if (v1) e1 = 1'b1;
      end
      #1;
      chk("arb_r0_ready", r0_ready, e0);
      chk("arb_r1_ready", r1_ready, e1);
      if (e0) begin exp_q.push_back(rsp_t'{src: 1'b0, tag: t0v, err: 1'b0}); mode_q.push_back(m0); end
      if (e1) begin exp_q.push_back(rsp_t'{src: 1'b1, tag: t1v, err: 1'b0}); mode_q.push_back(m1); end
      if (e0 || e1) begin
        occ++;
        if (g0 < 0) g0 = cyc;
      end
      if (g0 >= 0 && cyc == g0 + 1) occ--;
      step();
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_src"}, rsp_src, 0);
    chk({pfx, "_rsp_tag"}, rsp_tag, 0);
    chk({pfx, "_rsp_err"}, rsp_err, 0);
    chk({pfx, "_au_start"}, au_start, 0);
    chk({pfx, "_au_mode"}, au_mode, 0);
    chk({pfx, "_sched_busy"}, sched_busy, 0);
    chk({pfx, "_fifo_count"}, fifo_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, at, b, sc;
    logic [TAG_W-1:0] tg;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Single request: start at t+2, response at t+262
    push1(1'b0, MODE_SUB, 3'd5, 1'b0, t);
    wait_ev(1'b0, 10, at);
    chk("t1_start_cyc", at, t + 2);
    chk("t1_start_mode", au_mode, 1);
    wait_ev(1'b1, 400, at);
    chk("t1_rsp_cyc", at, t + 3 + LAT);
    chk("t1_rsp_src", rsp_src, 0);
    chk("t1_rsp_tag", rsp_tag, 5);
    chk("t1_rsp_err", rsp_err, 0);
    step();
    chk("t1_idle_busy", sched_busy, 0);
    chk("t1_rsp_drop", rsp_valid, 0);

    // Contested requests: grants alternate r0,r1,r0,r1
    arb_phase(4, 1'b1);
    drain(1500);

    // Random request patterns including FIFO full
    arb_phase(12, 1'b0);
    drain(2000);

    // Fill FIFO behind an in-flight op; 5th request waits for the first pop
    push1(1'b0, 1'($urandom), TAG_W'($urandom), 1'b0, t);
    for (int i = 0; i < DEPTH; i++) push1(1'b1, 1'($urandom), TAG_W'($urandom), 1'b0, t2);
    chk("t3_count_full", fifo_count, DEPTH);
    tg = TAG_W'($urandom);
    r0_valid = 1'b1; r0_mode = 1'b1; r0_tag = tg;
    #1;
    chk("t3_ready_when_full", r0_ready, 0);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      if (r0_ready === 1'b1) begin at = cyc; break; end
      step();
      #1;
    end
    chk("t3_accept_cyc", at, t + 264);
    exp_q.push_back(rsp_t'{src: 1'b0, tag: tg, err: 1'b0});
    mode_q.push_back(1'b1);
    step();
    r0_valid = 1'b0;
    drain(2000);

    // Timeout: err=1 exactly TIMEOUT cycles after entering WAIT; no issue while busy
    done_en = 1'b0;
    push1(1'b1, MODE_ADD, 3'd6, 1'b1, t);
    wait_ev(1'b0, 10, at);
    hold_busy = 1'b1;
    chk("t4_start_cyc", at, t + 2);
    push1(1'b0, 1'($urandom), TAG_W'($urandom), 1'b0, t2);
    wait_ev(1'b1, 400, at);
    chk("t4_timeout_cyc", at, t + 3 + TIMEOUT);
    chk("t4_rsp_err", rsp_err, 1);
    sc = start_cnt;
    repeat (20) step();
    chk("t4_no_issue_busy", start_cnt, sc);
    chk("t4_sched_busy", sched_busy, 1);
    chk("t4_queued", fifo_count, 1);
    done_en = 1'b1;
    hold_busy = 1'b0;
    b = cyc;
    wait_ev(1'b0, 10, at);
    chk("t4_issue_after_busy", at, b + 1);
    drain(600);

    // Reset 100 cycles into an op with 2 queued
    push1(1'b0, 1'($urandom), TAG_W'($urandom), 1'b0, t);
    push1(1'b1, 1'($urandom), TAG_W'($urandom), 1'b0, t2);
    push1(1'b0, 1'($urandom), TAG_W'($urandom), 1'b0, t2);
    while (cyc < t + 102) step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    exp_q.delete();
    mode_q.delete();
    rr_m = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (300) step();
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", sched_busy, 0);

    // Spurious done while idle and empty
    spur = 1'b1;
    step();
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_rsp", rsp_valid, 0);
      chk("t6_idle", sched_busy, 0);
    end
    tg = TAG_W'($urandom);
    push1(1'b1, 1'b0, tg, 1'b0, t);
    wait_ev(1'b1, 400, at);
    chk("t6_rsp_cyc", at, t + 3 + LAT);
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
